// File: rtl/nf_uart_rx_fsm.sv
// UART 8N1 receiver: synchronizer, mid-bit sampling FSM, held byte with ack/overrun.
// Latency: rx_valid rises 9*comp_e + (comp_e>>1) + SYNC_STAGES + 1 clocks after the start-bit falling edge.
// Backpressure: a byte is held until rx_ack; a new byte arriving unacknowledged overwrites it and sets overrun.
//
// Ports:
//   clk, resetn      clock and asynchronous reset (asserted high)
//   comp             clocks per bit, clamped below at COMP_MIN, latched at start of frame
//   rx_en            receiver enable; dropping it mid-frame aborts the frame
//   uart_rx          serial line, idle high
//   rx_data/rx_valid received byte, held until rx_ack
//   rx_ack           consumer acknowledge, only honoured while rx_valid=1
//   frame_err        one-cycle pulse when the stop bit reads low
//   overrun          sticky until ack: a byte was overwritten before being acknowledged
//   busy             receiver is anywhere but IDLE
module nf_uart_rx_fsm #(
  parameter int SYNC_STAGES = 2,  // 2..3
  parameter int COMP_MIN    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] comp,
  input  logic        rx_en,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] COMP_MIN_W = 16'(COMP_MIN);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [15:0]            comp_q;
  logic [15:0]            timer_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;

  logic        rx_s;
  logic [15:0] comp_in_e;
  logic        half_hit;
  logic        bit_hit;
  logic        deliver;
  logic        ack_take;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign comp_in_e = (comp < COMP_MIN_W) ? COMP_MIN_W : comp;

  // comp_q >= COMP_MIN keeps both targets non-negative, so the timer
  // always meets its target with exact equality and never wraps.
  assign half_hit  = (timer_q == ((comp_q >> 1) - 16'd1));
  assign bit_hit   = (timer_q == (comp_q - 16'd1));

  assign deliver   = (state_q == S_STOP) && rx_en && bit_hit && rx_s;
  assign ack_take  = rx_valid && rx_ack;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q   <= S_IDLE;
      sync_q    <= '1;
      comp_q    <= '0;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      frame_err <= 1'b0;

      // Output holding register. An ack in the same cycle as a delivery
      // consumes the old byte, so the new one is not an overrun.
      if (deliver) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
        if (ack_take) begin
          overrun <= 1'b0;
        end else if (rx_valid) begin
          overrun <= 1'b1;
        end
      end else if (ack_take) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (rx_en && !rx_s) begin
            state_q <= S_START;
            timer_q <= '0;
            comp_q  <= comp_in_e;
            busy    <= 1'b1;
          end
        end

        S_START: begin
          if (!rx_en) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (half_hit) begin
            if (!rx_s) begin
              state_q   <= S_DATA;
              timer_q   <= '0;
              bit_idx_q <= '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        S_DATA: begin
          if (!rx_en) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (bit_hit) begin
            shift_q[bit_idx_q] <= rx_s;
            timer_q            <= '0;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        S_STOP: begin
          if (!rx_en) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end else if (bit_hit) begin
            if (rx_s) begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_q   <= S_BREAK;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        S_BREAK: begin
          // Wait out the low line so a long break cannot look like a start bit.
          if (rx_s) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_uart_rx_fsm.sv
// Directed bench for nf_uart_rx_fsm: serial frames driven on negedges, outputs sampled on negedges.
module tb_nf_uart_rx_fsm;

  logic        clk;
  logic        resetn;
  logic [15:0] comp;
  logic        rx_en;
  logic        uart_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int fe_cycles   = 0;
  int ov_cycles   = 0;

  nf_uart_rx_fsm #(.SYNC_STAGES(2), .COMP_MIN(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .comp      (comp),
    .rx_en     (rx_en),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cycles++;
    if (overrun)   ov_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Must be called at a negedge; returns at a negedge with the stop level still driven.
  task automatic send_byte(input logic [7:0] d, input int period, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (period) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (period) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  logic [7:0] msg [12];
  int cnt;
  int fe0;
  int ov0;

  initial begin
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
            8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    resetn  = 1'b1;
    rx_en   = 1'b1;
    rx_ack  = 1'b0;
    uart_rx = 1'b1;
    comp    = 16'd434;
    repeat (3) @(negedge clk);

    check("rst_rx_data",   {24'd0, rx_data}, 32'h00);
    check("rst_rx_valid",  {31'd0, rx_valid}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_overrun",   {31'd0, overrun}, 0);
    check("rst_busy",      {31'd0, busy}, 0);

    resetn = 1'b0;
    repeat (5) @(negedge clk);

    // 0x55 at comp=434, rx_valid must rise 4125..4127 clocks after the falling edge
    fe0 = fe_cycles;
    fork
      send_byte(8'h55, 434, 1'b1);
      begin
        cnt = 0;
        while (!rx_valid && cnt < 6000) begin
          @(negedge clk);
          cnt++;
        end
      end
    join
    check($sformatf("latency_window_cnt_%0d", cnt), {31'd0, (cnt >= 4125 && cnt <= 4127)}, 1);
    check("b55_data",  {24'd0, rx_data}, 32'h55);
    check("b55_valid", {31'd0, rx_valid}, 1);
    check("b55_ferr",  fe_cycles - fe0, 0);
    ack_pulse();
    check("b55_ack_valid", {31'd0, rx_valid}, 0);

    // Start-bit glitch: 100 low clocks, decision at mid start bit (220 clocks)
    fe0 = fe_cycles;
    uart_rx = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy_mid", {31'd0, busy}, 1);
    uart_rx = 1'b1;
    cnt = 0;
    while (busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("glitch_busy_fall_%0d", 100 + cnt), {31'd0, (100 + cnt <= 220) && !busy}, 1);
    check("glitch_valid", {31'd0, rx_valid}, 0);
    check("glitch_ferr",  fe_cycles - fe0, 0);
    repeat (10) @(negedge clk);

    // Back-to-back 'H','i' without ack -> overrun
    comp = 16'd20;
    send_byte(8'h48, 20, 1'b1);
    check("h_data",    {24'd0, rx_data}, 32'h48);
    check("h_overrun", {31'd0, overrun}, 0);
    send_byte(8'h69, 20, 1'b1);
    check("i_data",    {24'd0, rx_data}, 32'h69);
    check("i_valid",   {31'd0, rx_valid}, 1);
    check("i_overrun", {31'd0, overrun}, 1);
    ack_pulse();
    check("ovr_ack_valid",   {31'd0, rx_valid}, 0);
    check("ovr_ack_overrun", {31'd0, overrun}, 0);
    repeat (5) @(negedge clk);

    // 0xA5 with a low stop bit, then a 2000-clock break
    fe0 = fe_cycles;
    send_byte(8'hA5, 20, 1'b0);
    repeat (2000) @(negedge clk);
    check("brk_ferr_cycles", fe_cycles - fe0, 1);
    check("brk_valid",       {31'd0, rx_valid}, 0);
    check("brk_busy",        {31'd0, busy}, 1);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_idle_busy",   {31'd0, busy}, 0);
    send_byte(8'h3C, 20, 1'b1);
    check("after_brk_data",  {24'd0, rx_data}, 32'h3C);
    check("after_brk_valid", {31'd0, rx_valid}, 1);
    check("brk_ferr_total",  fe_cycles - fe0, 1);

    // Reset during data bit 4 (0x3C still held, unacknowledged)
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = (i == 1 || i == 3);
      repeat (20) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("midframe_busy", {31'd0, busy}, 1);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_rx_data",   {24'd0, rx_data}, 32'h00);
    check("mrst_rx_valid",  {31'd0, rx_valid}, 0);
    check("mrst_frame_err", {31'd0, frame_err}, 0);
    check("mrst_overrun",   {31'd0, overrun}, 0);
    check("mrst_busy",      {31'd0, busy}, 0);
    resetn = 1'b0;
    repeat (30) @(negedge clk);
    send_byte(8'hA3, 20, 1'b1);
    check("a3_data",  {24'd0, rx_data}, 32'hA3);
    check("a3_valid", {31'd0, rx_valid}, 1);
    ack_pulse();
    repeat (5) @(negedge clk);

    // comp below the floor is clamped to 4 clocks per bit
    comp = 16'd1;
    send_byte(8'hC9, 4, 1'b1);
    repeat (10) @(negedge clk);
    check("clamp_data",  {24'd0, rx_data}, 32'hC9);
    check("clamp_valid", {31'd0, rx_valid}, 1);
    check("clamp_busy",  {31'd0, busy}, 0);
    ack_pulse();
    repeat (5) @(negedge clk);

    // "Hello World!" with acks; 'W' delivery coincides with the ack of ' '
    comp = 16'd20;
    ov0 = ov_cycles;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        fork
          send_byte(msg[i], 20, 1'b1);
          begin
            // delivery edge is 3 + 10 + 9*20 = 193 clocks after the falling edge
            repeat (192) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
          end
        join
        check("hello_coinc_valid",   {31'd0, rx_valid}, 1);
        check("hello_coinc_overrun", {31'd0, overrun}, 0);
      end else begin
        send_byte(msg[i], 20, 1'b1);
      end
      check($sformatf("hello_byte_%0d", i), {24'd0, rx_data}, {24'd0, msg[i]});
      if (i != 5) begin
        ack_pulse();
        check($sformatf("hello_ack_%0d", i), {31'd0, rx_valid}, 0);
      end
    end
    check("hello_overrun_never", ov_cycles - ov0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
